// File: rtl/branch_predictor_table.sv
// Indexed branch predictor: per-entry valid/tag/target/2-bit counter, bimodal or gshare indexing,
// combinational fetch lookup, decode-stage write-back and saturating branch/mispredict statistics.
module branch_predictor_table #(
   parameter int unsigned PC_WIDTH     = 8,
   parameter int unsigned INDEX_BITS   = 4,
   parameter int unsigned GHR_BITS     = 4,
   parameter int unsigned MODE         = 0,
   parameter logic [1:0]  COUNTER_INIT = 2'b01,
   parameter int unsigned STAT_BITS    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [PC_WIDTH-1:0]   fetch_pc,
   output logic                  predict_taken,
   output logic [PC_WIDTH-1:0]   predict_target,
   output logic                  predict_hit,
   output logic [INDEX_BITS-1:0] predict_index,
   input  logic                  update_valid,
   input  logic [PC_WIDTH-1:0]   update_pc,
   input  logic [INDEX_BITS-1:0] update_index,
   input  logic                  update_taken,
   input  logic                  update_pred_taken,
   input  logic [PC_WIDTH-1:0]   update_target,
   output logic                  mispredict,
   output logic [STAT_BITS-1:0]  branch_count,
   output logic [STAT_BITS-1:0]  mispredict_count
);

   localparam int unsigned ENTRIES = 1 << INDEX_BITS;

   logic                  r_valid  [ENTRIES];
   logic [PC_WIDTH-1:0]   r_tag    [ENTRIES];
   logic [PC_WIDTH-1:0]   r_target [ENTRIES];
   logic [1:0]            r_ctr    [ENTRIES];
   logic [GHR_BITS-1:0]   r_ghr;
   logic [STAT_BITS-1:0]  r_branch_count;
   logic [STAT_BITS-1:0]  r_mispredict_count;

   logic [INDEX_BITS-1:0] w_ghr_idx;
   logic [INDEX_BITS-1:0] w_idx;
   logic                  w_hit;
   logic                  w_upd_hit;
   logic                  w_do_update;
   logic [1:0]            w_ctr_next;
   logic [GHR_BITS-1:0]   w_ghr_next;

   // History folds into the index by truncation (low bits kept) or zero-extension.
   if (GHR_BITS >= INDEX_BITS) begin : g_ghr_trunc
      assign w_ghr_idx = r_ghr[INDEX_BITS-1:0];
      if (GHR_BITS > INDEX_BITS) begin : g_ghr_hi
         logic w_unused_ghr_hi;
         assign w_unused_ghr_hi = ^r_ghr[GHR_BITS-1:INDEX_BITS];
      end
   end else begin : g_ghr_ext
      assign w_ghr_idx = {{(INDEX_BITS-GHR_BITS){1'b0}}, r_ghr};
   end

   if (GHR_BITS == 1) begin : g_ghr_one
      assign w_ghr_next = update_taken;
   end else begin : g_ghr_shift
      assign w_ghr_next = {r_ghr[GHR_BITS-2:0], update_taken};
   end

   always_comb begin
      w_idx = fetch_pc[INDEX_BITS-1:0];
      if (MODE == 1) w_idx = fetch_pc[INDEX_BITS-1:0] ^ w_ghr_idx;
   end

   assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == fetch_pc);
   assign predict_hit    = w_hit;
   assign predict_index  = w_idx;
   assign predict_taken  = w_hit && r_ctr[w_idx][1];
   assign predict_target = predict_taken ? r_target[w_idx] : fetch_pc + 1'b1;

   assign mispredict  = update_valid && (update_taken != update_pred_taken);
   assign w_do_update = enable && update_valid;
   assign w_upd_hit   = r_valid[update_index] && (r_tag[update_index] == update_pc);

   always_comb begin
      w_ctr_next = r_ctr[update_index];
      if (update_taken && (r_ctr[update_index] != 2'b11))
         w_ctr_next = r_ctr[update_index] + 2'b01;
      else if (!update_taken && (r_ctr[update_index] != 2'b00))
         w_ctr_next = r_ctr[update_index] - 2'b01;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= COUNTER_INIT;
         end
         r_ghr              <= '0;
         r_branch_count     <= '0;
         r_mispredict_count <= '0;
      end else if (w_do_update) begin
         if (w_upd_hit) begin
            r_ctr[update_index] <= w_ctr_next;
            if (update_taken) r_target[update_index] <= update_target;
         end else if (update_taken) begin
            r_valid[update_index]  <= 1'b1;
            r_tag[update_index]    <= update_pc;
            r_target[update_index] <= update_target;
            r_ctr[update_index]    <= 2'b10;
         end
         r_ghr <= w_ghr_next;
         if (r_branch_count != '1) r_branch_count <= r_branch_count + 1'b1;
         if (mispredict && (r_mispredict_count != '1))
            r_mispredict_count <= r_mispredict_count + 1'b1;
      end
   end

   assign branch_count     = r_branch_count;
   assign mispredict_count = r_mispredict_count;

endmodule
